// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses PLL RESET, waits for a stable synchronized lock,
// retries on timeout and gates the downstream video reset.
module pll_lock_supervisor #(
    parameter int unsigned RESET_CYCLES  = 27,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned STABLE_CYCLES = 2700,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       pll_rst_req,
    output logic       pll_reset,
    output logic       sys_resetn,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retries,
    output logic [7:0] lost_count
);

    localparam int unsigned CMAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ?
                                     RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CMAX   = (CMAX_A > STABLE_CYCLES) ?
                                     CMAX_A : STABLE_CYCLES;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RTY_LIM  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          cnt_clr;
    logic [3:0]    retries_n;
    logic [7:0]    lost_n;
    logic          lock_m;
    logic          lock_s;

    // pll_lock is asynchronous to clkin
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        retries_n = retries;
        lost_n    = lost_count;
        if (pll_rst_req) begin
            state_n   = S_PLL_RST;
            cnt_clr   = 1'b1;
            retries_n = '0;
        end else begin
            unique case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) state_n = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = S_STABLE;
                    end else if (cnt == TMO_LAST) begin
                        retries_n = retries + 4'd1;
                        state_n   = (retries_n == RTY_LIM) ? S_FAIL : S_PLL_RST;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) state_n = S_WAIT_LOCK;
                    else if (cnt == STB_LAST) state_n = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_n   = S_PLL_RST;
                        retries_n = '0;
                        if (lost_count != 8'hFF) lost_n = lost_count + 8'd1;
                    end
                end
                S_FAIL: begin
                    state_n = S_FAIL;
                end
                default: begin
                    state_n = S_PLL_RST;
                end
            endcase
        end
        if (state_n != state) cnt_clr = 1'b1;
        // counter only matters in the timed states; hold it elsewhere
        if (cnt_clr) cnt_n = '0;
        else if (state == S_RUN || state == S_FAIL) cnt_n = cnt;
        else cnt_n = cnt + 1'b1;
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state      <= S_PLL_RST;
            cnt        <= '0;
            retries    <= '0;
            lost_count <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            retries    <= retries_n;
            lost_count <= lost_n;
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            pll_reset  <= 1'b1;
            sys_resetn <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            pll_reset  <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
            sys_resetn <= (state_n == S_RUN);
            locked     <= (state_n == S_RUN);
            fail       <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: per-cycle expected outputs are queued
// alongside the stimulus and compared on the falling edge.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       pll_rst_req;
    logic       pll_reset;
    logic       sys_resetn;
    logic       locked;
    logic       fail;
    logic [3:0] retries;
    logic [7:0] lost_count;
    logic [15:0] outs;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          at;
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clkin      (clkin),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .pll_rst_req(pll_rst_req),
        .pll_reset  (pll_reset),
        .sys_resetn (sys_resetn),
        .locked     (locked),
        .fail       (fail),
        .retries    (retries),
        .lost_count (lost_count)
    );

    always #5 clkin = ~clkin;

    assign outs = {pll_reset, sys_resetn, locked, fail, retries, lost_count};

    // cycle 0 is the interval right after resetn deasserts
    always @(posedge clkin) begin
        if (!resetn) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic pr, input logic sr,
                                       input logic lk, input logic fl,
                                       input logic [3:0] r,
                                       input logic [7:0] l);
        return {pr, sr, lk, fl, r, l};
    endfunction

    task automatic want(input int a, input int b, input string tag,
                        input logic [15:0] v);
        for (int c = a; c <= b; c++) sb.push_back('{at: c, tag: tag, val: v});
    endtask

    always @(negedge clkin) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, outs, e.val);
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic release_rst();
        resetn = 1'b0;
        @(posedge clkin);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [7:0] lc;
        int t;
        resetn      = 1'b0;
        pll_lock    = 1'b0;
        pll_rst_req = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        chk("reset_state", outs, mk(1, 0, 0, 0, 0, 0));

        // nominal release
        release_rst();
        want(0, 3, "nom_pllrst", mk(1, 0, 0, 0, 0, 0));
        want(4, 20, "nom_wait", mk(0, 0, 0, 0, 0, 0));
        want(21, 25, "nom_run", mk(0, 1, 1, 0, 0, 0));
        goto(10);
        pll_lock = 1'b1;
        goto(26);

        // lock glitch during STABLE
        pll_lock = 1'b0;
        release_rst();
        want(0, 3, "gl_pllrst", mk(1, 0, 0, 0, 0, 0));
        want(4, 30, "gl_hold", mk(0, 0, 0, 0, 0, 0));
        want(31, 33, "gl_run", mk(0, 1, 1, 0, 0, 0));
        goto(10);
        pll_lock = 1'b1;
        goto(15);
        pll_lock = 1'b0;
        goto(20);
        pll_lock = 1'b1;
        goto(34);

        // timeouts into FAIL
        pll_lock = 1'b0;
        release_rst();
        want(0, 3, "to_pllrst0", mk(1, 0, 0, 0, 0, 0));
        want(4, 23, "to_wait0", mk(0, 0, 0, 0, 0, 0));
        want(24, 27, "to_pllrst1", mk(1, 0, 0, 0, 1, 0));
        want(28, 47, "to_wait1", mk(0, 0, 0, 0, 1, 0));
        want(48, 170, "to_fail", mk(1, 0, 0, 1, 2, 0));
        goto(170);

        // recovery from FAIL
        pll_rst_req = 1'b1;
        pll_lock    = 1'b1;
        want(171, 174, "rq_pllrst", mk(1, 0, 0, 0, 0, 0));
        want(175, 183, "rq_wait", mk(0, 0, 0, 0, 0, 0));
        want(184, 194, "rq_run", mk(0, 1, 1, 0, 0, 0));
        goto(171);
        pll_rst_req = 1'b0;

        // repeated one-cycle lock loss
        for (int i = 0; i < 300; i++) begin
            t  = 195 + 20 * i;
            lc = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            goto(t);
            want(t, t + 2, "ll_run",
                 mk(0, 1, 1, 0, 0, (i > 255) ? 8'd255 : 8'(i)));
            want(t + 3, t + 6, "ll_pllrst", mk(1, 0, 0, 0, 0, lc));
            want(t + 7, t + 15, "ll_wait", mk(0, 0, 0, 0, 0, lc));
            want(t + 16, t + 19, "ll_rerun", mk(0, 1, 1, 0, 0, lc));
            pll_lock = 1'b0;
            goto(t + 1);
            pll_lock = 1'b1;
        end

        // async reset while in STABLE
        t = 195 + 20 * 300;
        goto(t);
        want(t, t + 2, "ar_run", mk(0, 1, 1, 0, 0, 8'd255));
        want(t + 3, t + 6, "ar_pllrst", mk(1, 0, 0, 0, 0, 8'd255));
        want(t + 7, t + 10, "ar_stable", mk(0, 0, 0, 0, 0, 8'd255));
        pll_lock = 1'b0;
        goto(t + 1);
        pll_lock = 1'b1;
        goto(t + 11);
        resetn = 1'b0;
        #1;
        chk("async_rst", outs, mk(1, 0, 0, 0, 0, 0));
        @(posedge clkin);
        #1;
        chk("rst_hold", outs, mk(1, 0, 0, 0, 0, 0));
        resetn = 1'b1;
        want(0, 3, "ar2_pllrst", mk(1, 0, 0, 0, 0, 0));
        want(4, 12, "ar2_wait", mk(0, 0, 0, 0, 0, 0));
        want(13, 15, "ar2_run", mk(0, 1, 1, 0, 0, 0));
        goto(16);

        chk("sb_drain", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
